// File: rtl/spi_flash_model.sv
// SPI NOR flash slave model (mode 0) serving the 0x03 READ command from a
// byte array preloaded through a backdoor write port. SPI pins are
// oversampled by the system clock, so the whole block is single-clock.
// Optional build macro: FLASH_FAST_READ_EN adds the 0x0B FAST READ command
// (24 address bits followed by 8 dummy clocks).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | deselected, or waiting for a fresh ss_n falling edge
// ST_CMD    | shifting in the 8-bit command byte
// ST_ADDR   | shifting in the 24-bit byte address
// ST_DUMMY  | FAST READ only: 8 dummy clocks before data
// ST_DATA   | streaming array bytes on miso, address auto-increments
// ST_IGNORE | unsupported command, miso parked until deselect
module spi_flash_model #(
  parameter int   ADDR_W       = 24,
  parameter int   SCK_MIN_HALF = 4,
  parameter logic RST_MISO     = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_wdata,
  output logic              cmd_err
);

  // Two sync flops plus one edge flop need at least 2 clocks per sck phase.
  if (SCK_MIN_HALF < 2) begin : g_half_chk
    $error("spi_flash_model: SCK_MIN_HALF must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_e;

  logic [7:0] mem_q [2**ADDR_W];

  logic sck_meta_q, sck_s_q, sck_d_q;
  logic ss_meta_q, ss_s_q;
  logic mosi_meta_q, mosi_s_q;
  logic ss_armed_q;

  state_e            state_q;
  logic [4:0]        bit_cnt_q;
  logic [22:0]       shift_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        tx_q;
  logic [2:0]        bit_idx_q;
  logic              reload_q;
  logic              miso_q;
  logic              cmd_err_q;
`ifdef FLASH_FAST_READ_EN
  logic              fast_q;
`endif

  logic              sck_rise, sck_fall;
  logic [23:0]       shift_d;
  logic [ADDR_W-1:0] addr_in_d;
  logic [ADDR_W-1:0] addr_inc_d;
  logic [7:0]        rd_byte_d;

  assign sck_rise   = sck_s_q & ~sck_d_q;
  assign sck_fall   = ~sck_s_q & sck_d_q;
  assign shift_d    = {shift_q, mosi_s_q};
  assign addr_in_d  = shift_d[ADDR_W-1:0];
  assign addr_inc_d = addr_q + ADDR_W'(1);
  assign rd_byte_d  = mem_q[addr_inc_d];

  assign spi_miso = miso_q;
  assign cmd_err  = cmd_err_q;

  // Backdoor byte writes; the array is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  // Pin synchronisers. The ss_n chain resets low (not deselected) so that a
  // select held low across reset never looks like a fresh falling edge;
  // ss_armed_q only sets once ss_n has genuinely been seen high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_meta_q  <= 1'b0;
      sck_s_q     <= 1'b0;
      sck_d_q     <= 1'b0;
      ss_meta_q   <= 1'b0;
      ss_s_q      <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      sck_meta_q  <= spi_sck;
      sck_s_q     <= sck_meta_q;
      sck_d_q     <= sck_s_q;
      ss_meta_q   <= spi_ss_n;
      ss_s_q      <= ss_meta_q;
      mosi_meta_q <= spi_mosi;
      mosi_s_q    <= mosi_meta_q;
    end
  end

  // Protocol FSM with registered miso and cmd_err.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 5'd0;
      shift_q    <= '0;
      addr_q     <= '0;
      tx_q       <= 8'h00;
      bit_idx_q  <= 3'd7;
      reload_q   <= 1'b0;
      miso_q     <= RST_MISO;
      cmd_err_q  <= 1'b0;
      ss_armed_q <= 1'b0;
`ifdef FLASH_FAST_READ_EN
      fast_q     <= 1'b0;
`endif
    end else begin
      cmd_err_q <= 1'b0;
      if (ss_s_q) begin
        // Deselect wins over any simultaneous sck edge, from every state.
        state_q    <= ST_IDLE;
        bit_cnt_q  <= 5'd0;
        miso_q     <= RST_MISO;
        reload_q   <= 1'b0;
        ss_armed_q <= 1'b1;
`ifdef FLASH_FAST_READ_EN
        fast_q     <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            miso_q <= RST_MISO;
            if (ss_armed_q) begin
              state_q   <= ST_CMD;
              bit_cnt_q <= 5'd0;
            end
          end

          ST_CMD: begin
            if (sck_rise) begin
              shift_q <= shift_d[22:0];
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= 5'd0;
                if (shift_d[7:0] == 8'h03) begin
                  state_q <= ST_ADDR;
`ifdef FLASH_FAST_READ_EN
                end else if (shift_d[7:0] == 8'h0B) begin
                  state_q <= ST_ADDR;
                  fast_q  <= 1'b1;
`endif
                end else begin
                  state_q   <= ST_IGNORE;
                  cmd_err_q <= 1'b1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end

          ST_ADDR: begin
            if (sck_rise) begin
              shift_q <= shift_d[22:0];
              if (bit_cnt_q == 5'd23) begin
                bit_cnt_q <= 5'd0;
                addr_q    <= addr_in_d;
`ifdef FLASH_FAST_READ_EN
                if (fast_q) begin
                  state_q <= ST_DUMMY;
                end else begin
                  state_q   <= ST_DATA;
                  tx_q      <= mem_q[addr_in_d];
                  bit_idx_q <= 3'd7;
                  reload_q  <= 1'b0;
                end
`else
                state_q   <= ST_DATA;
                tx_q      <= mem_q[addr_in_d];
                bit_idx_q <= 3'd7;
                reload_q  <= 1'b0;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end

`ifdef FLASH_FAST_READ_EN
          ST_DUMMY: begin
            if (sck_rise) begin
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= 5'd0;
                state_q   <= ST_DATA;
                tx_q      <= mem_q[addr_q];
                bit_idx_q <= 3'd7;
                reload_q  <= 1'b0;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
`endif

          ST_DATA: begin
            if (sck_fall) begin
              if (reload_q) begin
                // Previous byte fully shifted: advance (wrapping) and send bit 7.
                addr_q    <= addr_inc_d;
                tx_q      <= rd_byte_d;
                miso_q    <= rd_byte_d[7];
                bit_idx_q <= 3'd6;
                reload_q  <= 1'b0;
              end else begin
                miso_q <= tx_q[bit_idx_q];
                if (bit_idx_q == 3'd0) begin
                  reload_q <= 1'b1;
                end else begin
                  bit_idx_q <= bit_idx_q - 3'd1;
                end
              end
            end
          end

          ST_IGNORE: begin
            miso_q <= RST_MISO;
          end

          default: begin
            state_q <= ST_IDLE;
            miso_q  <= RST_MISO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_model.sv
// Directed bench for spi_flash_model: a mode-0 SPI master with half-period
// HALF clocks, backdoor preloads, and inline checks per scenario.
module tb_spi_flash_model;

  localparam int ADDR_W = 24;
  localparam int HALF   = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              spi_sck = 1'b0;
  logic              spi_ss_n = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso;
  logic              mem_we = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [7:0]        mem_wdata = 8'h00;
  logic              cmd_err;

  int vec_cnt = 0;
  int miscompares = 0;
  int err_pulses = 0;

  spi_flash_model #(
    .ADDR_W(ADDR_W),
    .SCK_MIN_HALF(HALF),
    .RST_MISO(1'b0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .spi_sck(spi_sck),
    .spi_ss_n(spi_ss_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cmd_err(cmd_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (cmd_err === 1'b1) err_pulses++;
  end

  task automatic bd_write(input logic [23:0] a, input logic [7:0] d);
    @(negedge clock);
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    @(negedge clock);
    mem_we    = 1'b0;
  endtask

  // One sck period: mosi set while low, miso sampled just before the rise.
  task automatic sck_bit(input logic mo, output logic mi);
    spi_mosi = mo;
    repeat (HALF) @(negedge clock);
    mi = spi_miso;
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clock);
    spi_sck = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      sck_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic select();
    @(negedge clock);
    spi_ss_n = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic deselect();
    repeat (HALF) @(negedge clock);
    spi_ss_n = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] rx;
    xfer_byte(cmd, rx);
    xfer_byte(a[23:16], rx);
    xfer_byte(a[15:8], rx);
    xfer_byte(a[7:0], rx);
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    spi_ss_n = 1'b1;
    repeat (3) @(negedge clock);
    vec_cnt++;
    if (spi_miso !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_miso: got %b want 0", spi_miso);
    end
    vec_cnt++;
    if (cmd_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cmd_err: got %b want 0", cmd_err);
    end
    reset = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic test_read();
    logic [7:0] rx;
    logic [7:0] exp [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    err_pulses = 0;
    select();
    send_hdr(8'h03, 24'h000100);
    for (int i = 0; i < 4; i++) begin
      xfer_byte(8'h00, rx);
      vec_cnt++;
      if (rx !== exp[i]) begin
        miscompares++;
        $display("FAIL read_byte%0d: got %h want %h", i, rx, exp[i]);
      end
    end
    deselect();
    vec_cnt++;
    if (err_pulses != 0) begin
      miscompares++;
      $display("FAIL read_no_cmd_err: got %0d pulses want 0", err_pulses);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] rx;
    select();
    send_hdr(8'h03, 24'hFFFFFF);
    xfer_byte(8'h00, rx);
    vec_cnt++;
    if (rx !== 8'h11) begin
      miscompares++;
      $display("FAIL wrap_top: got %h want 11", rx);
    end
    xfer_byte(8'h00, rx);
    vec_cnt++;
    if (rx !== 8'h22) begin
      miscompares++;
      $display("FAIL wrap_zero: got %h want 22", rx);
    end
    deselect();
  endtask

  task automatic test_cmd_err();
    logic [7:0] rx;
    err_pulses = 0;
    select();
    xfer_byte(8'h9F, rx);
    vec_cnt++;
    if (err_pulses != 1) begin
      miscompares++;
      $display("FAIL cmd_err_pulse: got %0d cycles want 1", err_pulses);
    end
    for (int i = 0; i < 2; i++) begin
      xfer_byte(8'hA5, rx);
      vec_cnt++;
      if (rx !== 8'h00) begin
        miscompares++;
        $display("FAIL cmd_err_miso%0d: got %h want 00", i, rx);
      end
    end
    deselect();
    vec_cnt++;
    if (err_pulses != 1) begin
      miscompares++;
      $display("FAIL cmd_err_single: got %0d cycles want 1", err_pulses);
    end
    select();
    send_hdr(8'h03, 24'h000100);
    xfer_byte(8'h00, rx);
    vec_cnt++;
    if (rx !== 8'hDE) begin
      miscompares++;
      $display("FAIL cmd_err_recover: got %h want DE", rx);
    end
    deselect();
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic b;
    select();
    send_hdr(8'h03, 24'h000100);
    for (int i = 0; i < 12; i++) sck_bit(1'b0, b);
    deselect();
    vec_cnt++;
    if (spi_miso !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle_miso: got %b want 0", spi_miso);
    end
    select();
    send_hdr(8'h03, 24'h000101);
    xfer_byte(8'h00, rx);
    vec_cnt++;
    if (rx !== 8'hAD) begin
      miscompares++;
      $display("FAIL abort_reread0: got %h want AD", rx);
    end
    xfer_byte(8'h00, rx);
    vec_cnt++;
    if (rx !== 8'hBE) begin
      miscompares++;
      $display("FAIL abort_reread1: got %h want BE", rx);
    end
    deselect();
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    logic b;
    select();
    xfer_byte(8'h03, rx);
    for (int i = 0; i < 10; i++) sck_bit(1'b0, b);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    vec_cnt++;
    if (spi_miso !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_miso_in_reset: got %b want 0", spi_miso);
    end
    reset = 1'b1;
    repeat (6) @(negedge clock);
    send_hdr(8'h03, 24'h000100);
    for (int i = 0; i < 2; i++) begin
      xfer_byte(8'h00, rx);
      vec_cnt++;
      if (rx !== 8'h00) begin
        miscompares++;
        $display("FAIL rstmid_quiet%0d: got %h want 00", i, rx);
      end
    end
    deselect();
    select();
    send_hdr(8'h03, 24'h000102);
    xfer_byte(8'h00, rx);
    vec_cnt++;
    if (rx !== 8'hBE) begin
      miscompares++;
      $display("FAIL rstmid_read: got %h want BE", rx);
    end
    deselect();
  endtask

  task automatic test_backdoor_inflight();
    logic [15:0] rx16;
    logic b;
    select();
    send_hdr(8'h03, 24'h000100);
    for (int i = 15; i >= 0; i--) begin
      if (i == 12) begin
        bd_write(24'h000100, 8'h00);
        bd_write(24'h000101, 8'h5A);
      end
      sck_bit(1'b0, b);
      rx16[i] = b;
    end
    deselect();
    vec_cnt++;
    if (rx16[15:8] !== 8'hDE) begin
      miscompares++;
      $display("FAIL bd_inflight_keep: got %h want DE", rx16[15:8]);
    end
    vec_cnt++;
    if (rx16[7:0] !== 8'h5A) begin
      miscompares++;
      $display("FAIL bd_next_reload: got %h want 5A", rx16[7:0]);
    end
    bd_write(24'h000100, 8'hDE);
    bd_write(24'h000101, 8'hAD);
  endtask

  task automatic test_fast_read();
    logic [7:0] rx;
    logic [7:0] d0, d1;
    err_pulses = 0;
    select();
    send_hdr(8'h0B, 24'h000100);
    xfer_byte(8'hFF, rx);
    xfer_byte(8'h00, d0);
    xfer_byte(8'h00, d1);
    deselect();
`ifdef FLASH_FAST_READ_EN
    vec_cnt++;
    if (d0 !== 8'hDE) begin
      miscompares++;
      $display("FAIL fast_byte0: got %h want DE", d0);
    end
    vec_cnt++;
    if (d1 !== 8'hAD) begin
      miscompares++;
      $display("FAIL fast_byte1: got %h want AD", d1);
    end
    vec_cnt++;
    if (err_pulses != 0) begin
      miscompares++;
      $display("FAIL fast_no_cmd_err: got %0d pulses want 0", err_pulses);
    end
`else
    vec_cnt++;
    if (err_pulses != 1) begin
      miscompares++;
      $display("FAIL fast_unsupported_err: got %0d cycles want 1", err_pulses);
    end
    vec_cnt++;
    if ({d0, d1} !== 16'h0000) begin
      miscompares++;
      $display("FAIL fast_unsupported_miso: got %h want 0000", {d0, d1});
    end
`endif
  endtask

  initial begin
    test_reset();
    bd_write(24'h000100, 8'hDE);
    bd_write(24'h000101, 8'hAD);
    bd_write(24'h000102, 8'hBE);
    bd_write(24'h000103, 8'hEF);
    bd_write(24'hFFFFFF, 8'h11);
    bd_write(24'h000000, 8'h22);
    test_read();
    test_wrap();
    test_cmd_err();
    test_abort();
    test_reset_mid();
    test_backdoor_inflight();
    test_fast_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_flash_model.md
Name: spi_flash_model

Overview:
- Downstream stage of the APB SPI master/XIP bridge: a single-clock SPI NOR flash slave that consumes its sck/ss/mosi pins and produces miso.
- Implements the 0x03 READ command over a byte-addressed internal array, which the bench or simulation top preloads through a backdoor write port.
- SPI pins are oversampled by the system clock, so the whole block lives in one clock domain.
- Used in npc simulation to close the flash XIP loop without an external behavioural model.

Parameters:
- ADDR_W, 24, byte-address width; array depth is 2**ADDR_W bytes.
- SCK_MIN_HALF, 4, minimum sck half-period in clock cycles that the block is guaranteed to track.
- RST_MISO, 1'b0, value driven on miso in reset and while deselected.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- spi_sck  in  1  SPI clock from the master, mode 0 (CPOL=0, CPHA=0).
- spi_ss_n  in  1  chip select, active-low.
- spi_mosi  in  1  master-out data, MSB first.
- spi_miso  out  1  slave-out data, MSB first.
- mem_we  in  1  backdoor byte write strobe.
- mem_addr  in  ADDR_W  backdoor byte address.
- mem_wdata  in  8  backdoor write data.
- cmd_err  out  1  one-cycle pulse when an unsupported command byte completes.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all counters and shift registers cleared, spi_miso=RST_MISO, cmd_err=0. Array contents are not cleared.
- Synchroniser: sck, ss_n and mosi each pass through 2 flops. A third sck flop provides edge detection.
  - rise = sck_s & ~sck_d; fall = ~sck_s & sck_d.
  - mosi is sampled from its synchronised copy on rise.
- ss_n synchronised high, in any state: next cycle state=IDLE, bit counter=0, spi_miso=RST_MISO. This takes priority over a simultaneous sck edge.
- IDLE: on synchronised ss_n falling to 0 -> CMD with bit_cnt=0.
- CMD: shift mosi in on each rise. On the 8th rise:
  - byte 0x03 -> ADDR.
  - any other byte -> IGNORE, with cmd_err=1 for exactly one cycle.
- ADDR: shift 24 bits. On the 24th rise, latch addr = shifted_value[ADDR_W-1:0]; upper bits are discarded when ADDR_W<24. Load tx_byte = mem[addr], bit_idx=7, then -> DATA.
- DATA:
  - On each fall, drive spi_miso = tx_byte[bit_idx], then decrement bit_idx.
  - After bit 0 is driven, the next fall first sets addr = addr+1 modulo 2**ADDR_W (wrap-around), reloads tx_byte from the new address, and drives its bit 7.
  - Reads stream without limit until ss_n deasserts.
  - mosi is ignored.
  - The first data bit is driven on the fall immediately after the 24th address rise. It is therefore valid before the master's 33rd rising edge.
- IGNORE: spi_miso=RST_MISO, all edges ignored until ss_n deasserts.
- Timing contract: correct only when every sck high and low phase is >= SCK_MIN_HALF clocks. Faster sck gives undefined data but never leaves a stuck state: ss_n high always recovers to IDLE.
- Backdoor write:
  - mem[mem_addr] <= mem_wdata on the clock edge where mem_we=1. Allowed in any state.
  - A write to the byte currently held in tx_byte does not alter the byte in flight. It is visible on the next reload.
- Reset asserted mid-transfer: immediate return to the reset values above. After reset deasserts, the block waits in IDLE for a fresh ss_n falling edge; a held-low ss_n does not restart CMD.

Optional Feature:
- Macro FLASH_FAST_READ_EN.
- Defined: command 0x0B is also accepted. It runs ADDR (24 bits), then DUMMY, which counts 8 further rises with mosi ignored. tx_byte is loaded at the end of DUMMY, and data output starts on the following fall as in DATA.
- Not defined: 0x0B is treated as unsupported, i.e. IGNORE plus a cmd_err pulse.

Test Plan:
- Preload 0x000100..0x000103 = DE AD BE EF. Send 0x03, 0x000100 and 32 further clocks with sck half-period 4 -> miso bytes DE AD BE EF; cmd_err stays 0.
- Preload 0xFFFFFF=0x11 and 0x000000=0x22 (ADDR_W=24). READ at 0xFFFFFF for 16 data clocks -> 0x11 then 0x22 (wrap).
- Send command 0x9F -> cmd_err high exactly 1 cycle after the 8th rise. spi_miso=0 for the remainder. Raise ss_n, then issue a READ of 0x000100 -> DE returned.
- Raise ss_n after 12 data bits of a READ at 0x000100 -> IDLE, miso=0. A new READ at 0x000101 -> AD BE.
- Assert reset=0 during ADDR phase bit 10 with ss_n held low, release reset -> no miso activity until ss_n goes high then low. A subsequent READ of 0x000102 -> BE.
- With FLASH_FAST_READ_EN: send 0x0B, 0x000100, 8 dummy clocks, 16 data clocks -> DE AD. Without the macro, the same stimulus -> cmd_err pulse and miso=0.
